// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory handshake
// and writes the IF_ID register. Redirects from decode squash or drain in-flight fetches.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
  parameter logic [31:0] BUBBLE_PC4 = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_IF_ID_Write,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic        interrupt,
  input  logic        exception,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_ID
);

  typedef enum logic {FETCH, DRAIN} state_t;

  localparam logic [63:0] BUBBLE = {BUBBLE_PC4, 32'h0000_0000};

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pend_target, pend_target_d;
  logic        hold_valid, hold_valid_d;
  logic [31:0] hold_instr, hold_instr_d;
  logic [31:0] hold_pc4, hold_pc4_d;
  logic [63:0] if_id_d;
  logic        redirect;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = ((state == FETCH) && !hold_valid) || (state == DRAIN);

  // Decode's control outputs are unreliable during a load-use stall.
  assign redirect = PC_IF_ID_Write & (interrupt | exception | JR | J | Z);

  always_comb begin
    if (interrupt)      target = IRQ_VECTOR;
    else if (exception) target = EXC_VECTOR;
    else if (JR)        target = jr_target;
    else if (J)         target = jump_target;
    else                target = branch_target;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    pend_target_d = pend_target;
    hold_valid_d  = hold_valid;
    hold_instr_d  = hold_instr;
    hold_pc4_d    = hold_pc4;
    if_id_d       = IF_ID;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          if_id_d      = BUBBLE;
          hold_valid_d = 1'b0;
          if (imem_req && !imem_ready) begin
            state_d       = DRAIN;
            pend_target_d = target;
          end else begin
            pc_d = target;
          end
        end else if (PC_IF_ID_Write) begin
          if (hold_valid) begin
            if_id_d      = {hold_pc4, hold_instr};
            hold_valid_d = 1'b0;
          end else if (imem_ready) begin
            if_id_d = {pc_plus4, imem_rdata};
            pc_d    = pc_plus4;
          end else begin
            if_id_d = BUBBLE;
          end
        end else if (imem_req && imem_ready) begin
          hold_instr_d = imem_rdata;
          hold_pc4_d   = pc_plus4;
          hold_valid_d = 1'b1;
          pc_d         = pc_plus4;
        end
      end

      DRAIN: begin
        if (PC_IF_ID_Write) if_id_d = BUBBLE;
        if (redirect) pend_target_d = target;
        if (imem_ready) begin
          // The late response belongs to the wrong path and is dropped.
          state_d = FETCH;
          pc_d    = redirect ? target : pend_target;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend_target <= 32'h0000_0000;
      hold_valid  <= 1'b0;
      IF_ID       <= BUBBLE;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_target <= pend_target_d;
      hold_valid  <= hold_valid_d;
      IF_ID       <= if_id_d;
    end
  end

  // NOTE: the holding buffer is qualified by hold_valid, so its data fields
  // need no reset and live in their own reset-free process.
  always_ff @(posedge clk) begin
    hold_instr <= hold_instr_d;
    hold_pc4   <= hold_pc4_d;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; the memory returns addr ^ 32'hA5A5_0000.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_IF_ID_Write;
  logic        Z, J, JR, interrupt, exception;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [63:0] IF_ID;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] BUB = {32'h8000_0000, 32'h0000_0000};

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_IF_ID_Write (PC_IF_ID_Write),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .interrupt      (interrupt),
    .exception      (exception),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .IF_ID          (IF_ID)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    Z = 1'b0; J = 1'b0; JR = 1'b0; interrupt = 1'b0; exception = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    PC_IF_ID_Write = 1'b1;
    clear_ctl();
    branch_target = '0; jump_target = '0; jr_target = '0;
    imem_ready = 1'b0;
    repeat (2) tick();
    check("reset_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0000});
    check("reset_req", {63'h0, imem_req}, 64'h1);
    check("reset_if_id", IF_ID, BUB);

    // Zero-wait sequential fetch
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    check("seq0_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0004});
    check("seq0_if_id", IF_ID, {32'h8000_0004, 32'h25A5_0000});
    tick();
    check("seq1_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0008});
    check("seq1_if_id", IF_ID, {32'h8000_0008, 32'h25A5_0004});

    // Stall: response for 0x80000008 is buffered, IF_ID holds
    PC_IF_ID_Write = 1'b0;
    tick();
    check("stall0_if_id", IF_ID, {32'h8000_0008, 32'h25A5_0004});
    check("stall0_req", {63'h0, imem_req}, 64'h0);
    check("stall0_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_000C});
    tick();
    check("stall1_if_id", IF_ID, {32'h8000_0008, 32'h25A5_0004});
    check("stall1_req", {63'h0, imem_req}, 64'h0);
    PC_IF_ID_Write = 1'b1;
    tick();
    check("release_if_id", IF_ID, {32'h8000_000C, 32'h25A5_0008});
    check("release_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_000C});
    check("release_req", {63'h0, imem_req}, 64'h1);
    tick();
    check("resume_if_id", IF_ID, {32'h8000_0010, 32'h25A5_000C});

    // Slow memory, branch during the wait, drain then redirect
    imem_ready = 1'b0;
    tick();
    check("wait_bubble", IF_ID, BUB);
    Z = 1'b1; branch_target = 32'h8000_0100;
    tick();
    clear_ctl();
    check("drain0_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0010});
    check("drain0_if_id", IF_ID, BUB);
    tick();
    check("drain1_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0010});
    check("drain1_req", {63'h0, imem_req}, 64'h1);
    imem_ready = 1'b1;
    tick();
    check("drain_done_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0100});
    check("drain_done_if_id", IF_ID, BUB);
    tick();
    check("target_if_id", IF_ID, {32'h8000_0104, 32'h25A5_0100});

    // Interrupt beats jump in the same cycle
    interrupt = 1'b1; J = 1'b1; jump_target = 32'h0040_0000;
    tick();
    clear_ctl();
    check("irq_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0004});
    check("irq_if_id", IF_ID, BUB);
    tick();
    check("irq_next_if_id", IF_ID, {32'h8000_0008, 32'h25A5_0004});

    // Branch ignored while stalled, honoured on the next cycle
    Z = 1'b1; branch_target = 32'h8000_0200; PC_IF_ID_Write = 1'b0;
    tick();
    check("stallbr_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_000C});
    check("stallbr_if_id", IF_ID, {32'h8000_0008, 32'h25A5_0004});
    PC_IF_ID_Write = 1'b1;
    tick();
    clear_ctl();
    check("br_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0200});
    check("br_if_id", IF_ID, BUB);
    check("br_req", {63'h0, imem_req}, 64'h1);

    // Redirect while draining overwrites the pending target
    imem_ready = 1'b0; J = 1'b1; jump_target = 32'h0040_0000;
    tick();
    clear_ctl();
    JR = 1'b1; jr_target = 32'h0050_0000;
    tick();
    clear_ctl();
    check("ovr_addr_hold", {32'h0, imem_addr}, {32'h0, 32'h8000_0200});
    imem_ready = 1'b1;
    tick();
    check("ovr_addr", {32'h0, imem_addr}, {32'h0, 32'h0050_0000});

    // Redirect coinciding with the drain response wins directly
    imem_ready = 1'b0; J = 1'b1;
    tick();
    clear_ctl();
    Z = 1'b1; branch_target = 32'h8000_0300; imem_ready = 1'b1;
    tick();
    clear_ctl();
    check("coinc_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0300});

    // Exception beats jump-register
    exception = 1'b1; JR = 1'b1; jr_target = 32'h0050_0000;
    tick();
    clear_ctl();
    check("exc_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0008});

    // PC+4 wraps modulo 2^32
    JR = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick();
    clear_ctl();
    check("wrap_pre_addr", {32'h0, imem_addr}, {32'h0, 32'hFFFF_FFFC});
    tick();
    check("wrap_addr", {32'h0, imem_addr}, 64'h0);
    check("wrap_if_id", IF_ID, {32'h0000_0000, 32'h5A5A_FFFC});

    // Asynchronous reset in the middle of a drain
    imem_ready = 1'b0; J = 1'b1; jump_target = 32'h0040_0000;
    tick();
    clear_ctl();
    check("rstdrain_req", {63'h0, imem_req}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0000});
    check("async_rst_if_id", IF_ID, BUB);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    check("post_rst_if_id", IF_ID, {32'h8000_0004, 32'h25A5_0000});
    check("post_rst_addr", {32'h0, imem_addr}, {32'h0, 32'h8000_0004});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
